// File: rtl/nubus_pkg.sv
// Shared types and helpers for the NuBus master request scheduler.
package nubus_pkg;

  // Scheduler states; the encoding is visible on state_q in the top for checkers.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_ISSUE = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } sched_state_e;

  localparam int NREQ_DEFAULT = 4;

  // Width needed to index n requesters (at least one bit).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nubus_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i,
// scanning upward with wrap. Output is one-hot or zero.
module nubus_rr_pick
  import nubus_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int PTR_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;

  // Scan last+1 .. last+NREQ (mod NREQ); the first hit wins, the rest are masked.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PTR_W'((int'(last_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nubus_master_sched.sv
// Round-robin scheduler sharing one NuBus master engine between NREQ local
// requesters, with bounded back-to-back chaining for locked requesters.
//
// Requester handshake: req_i[n] is a level held until done_o[n] or err_o[n]
// pulses for one clock; gnt_o[n] is high from selection through completion
// (and across chained locked transactions). A requester that drops req_i
// mid-transaction still receives its done/err pulse.
module nubus_master_sched
  import nubus_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int LOCK_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic            nub_clkn,
  input  logic            nub_resetn,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] lock_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] done_o,
  output logic [NREQ-1:0] err_o,
  output logic            sched_busy_o,
  output logic            mst_masterd_o,
  output logic            mst_lock_o,
  input  logic            mst_ownern_i,
  input  logic            mst_dtacyn_i,
  input  logic            mst_timeout_i,
  input  logic            nub_ackn
);

  localparam int              PTR_W     = clog2(NREQ);
  localparam logic [CNT_W:0]  CHAIN_LIM = (CNT_W+1)'(LOCK_MAX);

  sched_state_e     state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             ack_q, ack_d;

  logic [NREQ-1:0]  pick_gnt;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [CNT_W:0]   cnt_next;
  logic             chain_ok;
  logic             engine_idle;

  nubus_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (req_i),
    .last_i  (rr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // Encode the one-hot winner so it can become the new round-robin pointer.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end
  end

  // Chain decision: the held grant keeps the engine only if it was granted
  // locked, still requests with lock, and has chain budget left.
  always_comb begin
    cnt_next    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    engine_idle = mst_ownern_i && mst_dtacyn_i;
    chain_ok    = lock_q && (|(gnt_q & req_i)) && (|(gnt_q & lock_i)) &&
                  (cnt_next < CHAIN_LIM);
  end

  // State and datapath registers; reset points rr at NREQ-1 so requester 0 wins first.
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= PTR_W'(NREQ - 1);
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    ack_d   = ack_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) state_d = S_PICK;
      end
      S_PICK: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          lock_d  = |(pick_gnt & lock_i);
          rr_d    = pick_idx;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Leaving on the owner edge drops masterd next cycle, so the engine
        // does not start a second arbitration.
        if (!mst_ownern_i) state_d = S_XFER;
      end
      S_XFER: begin
        if (!mst_dtacyn_i && (!nub_ackn || mst_timeout_i)) begin
          ack_d   = !nub_ackn;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (engine_idle) begin
          if (chain_ok) begin
            cnt_d   = cnt_next[CNT_W-1:0];
            state_d = S_ISSUE;
          end else begin
            cnt_d   = '0;
            gnt_d   = '0;
            lock_d  = 1'b0;
            state_d = (|req_i) ? S_PICK : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; all zero in IDLE and therefore during reset.
  always_comb begin
    gnt_o         = gnt_q;
    done_o        = '0;
    err_o         = '0;
    mst_masterd_o = 1'b0;
    mst_lock_o    = 1'b0;
    sched_busy_o  = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        mst_masterd_o = 1'b1;
        mst_lock_o    = lock_q;
      end
      S_XFER: begin
        mst_lock_o = lock_q;
      end
      S_DONE: begin
        if (ack_q) done_o = gnt_q;
        else       err_o  = gnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nubus_master_sched.sv
// Directed bench for nubus_master_sched with a small master-engine model and
// a scoreboard of expected done/err pulses.
module tb_nubus_master_sched;

  localparam int NREQ = 4;
  localparam int W    = 2 * NREQ + 1;   // {lock seen in XFER, done vector, err vector}

  logic            nub_clkn = 1'b0;
  logic            nub_resetn;
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] lock_i;
  logic [NREQ-1:0] gnt_o;
  logic [NREQ-1:0] done_o;
  logic [NREQ-1:0] err_o;
  logic            sched_busy_o;
  logic            mst_masterd_o;
  logic            mst_lock_o;
  logic            mst_ownern_i;
  logic            mst_dtacyn_i;
  logic            mst_timeout_i;
  logic            nub_ackn;

  nubus_master_sched #(
    .NREQ     (NREQ),
    .LOCK_MAX (4),
    .CNT_W    (3)
  ) dut (
    .nub_clkn      (nub_clkn),
    .nub_resetn    (nub_resetn),
    .req_i         (req_i),
    .lock_i        (lock_i),
    .gnt_o         (gnt_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .sched_busy_o  (sched_busy_o),
    .mst_masterd_o (mst_masterd_o),
    .mst_lock_o    (mst_lock_o),
    .mst_ownern_i  (mst_ownern_i),
    .mst_dtacyn_i  (mst_dtacyn_i),
    .mst_timeout_i (mst_timeout_i),
    .nub_ackn      (nub_ackn)
  );

  // ---------------- clock / reset ----------------
  always #5 nub_clkn = ~nub_clkn;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int rem[NREQ];
  int eng_mode = 0;   // 0: ACK after 3, 1: timeout after 256, 2: ACK+timeout together

  // ---------------- engine model (drives on negedge) ----------------
  int eph = 0;
  int ecnt = 0;
  always @(negedge nub_clkn) begin
    if (!nub_resetn) begin
      eph = 0; ecnt = 0;
      mst_ownern_i = 1'b1; mst_dtacyn_i = 1'b1; nub_ackn = 1'b1; mst_timeout_i = 1'b0;
    end else begin
      case (eph)
        0: begin
          if (mst_masterd_o) begin
            ecnt++;
            if (ecnt == 2) begin mst_ownern_i = 1'b0; eph = 1; end
          end else ecnt = 0;
        end
        1: begin mst_dtacyn_i = 1'b0; eph = 2; ecnt = 0; end
        2: begin
          ecnt++;
          if (eng_mode == 0 && ecnt == 3) begin nub_ackn = 1'b0; eph = 3; end
          else if (eng_mode == 1 && ecnt == 256) begin mst_timeout_i = 1'b1; eph = 3; end
          else if (eng_mode == 2 && ecnt == 3) begin
            nub_ackn = 1'b0; mst_timeout_i = 1'b1; eph = 3;
          end
        end
        default: begin
          mst_ownern_i = 1'b1; mst_dtacyn_i = 1'b1; nub_ackn = 1'b1; mst_timeout_i = 1'b0;
          eph = 0; ecnt = 0;
        end
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic lk, input logic [NREQ-1:0] g, input logic is_err);
    if (is_err) exp_q.push_back({lk, {NREQ{1'b0}}, g});
    else        exp_q.push_back({lk, g, {NREQ{1'b0}}});
  endtask

  // Requesters hold req while they have transactions left; each done/err consumes one.
  task automatic run_until_idle(input int budget, input string name);
    int n;
    bit finished;
    n = 0;
    finished = 0;
    for (int i = 0; i < NREQ; i++) req_i[i] = (rem[i] != 0);
    while (!finished && n < budget) begin
      @(posedge nub_clkn); #1;
      n++;
      for (int i = 0; i < NREQ; i++)
        if ((done_o[i] || err_o[i]) && rem[i] > 0) rem[i]--;
      for (int i = 0; i < NREQ; i++) req_i[i] = (rem[i] != 0);
      if (req_i == '0 && !sched_busy_o && exp_q.size() == 0) finished = 1;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s: not idle after %0d cycles, pending=%0d busy=%0b",
               name, budget, exp_q.size(), sched_busy_o);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_md = 1'b0;
  logic         prev_lock = 1'b0;
  logic [W-1:0] got;
  logic [W-1:0] e;
  always begin
    @(posedge nub_clkn); #1;
    if (!nub_resetn) begin
      prev_md = 1'b0; prev_lock = 1'b0;
    end else begin
      // masterd holds until owner is seen, then drops on that edge
      if (prev_md) begin
        checks++;
        if (mst_masterd_o !== mst_ownern_i) begin
          errors++;
          $display("FAIL masterd: got %0b expected %0b (ownern=%0b)",
                   mst_masterd_o, mst_ownern_i, mst_ownern_i);
        end
      end
      if ((done_o | err_o) != '0) begin
        got = {prev_lock, done_o, err_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got done=%b err=%b expected none", done_o, err_o);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL scoreboard: got lock=%0b done=%b err=%b expected lock=%0b done=%b err=%b",
                     got[W-1], got[2*NREQ-1:NREQ], got[NREQ-1:0],
                     e[W-1], e[2*NREQ-1:NREQ], e[NREQ-1:0]);
          end
          checks++;
          if (gnt_o !== (e[2*NREQ-1:NREQ] | e[NREQ-1:0])) begin
            errors++;
            $display("FAIL gnt_at_pulse: got %b expected %b", gnt_o,
                     e[2*NREQ-1:NREQ] | e[NREQ-1:0]);
          end
        end
      end
      prev_md   = mst_masterd_o;
      prev_lock = mst_lock_o;
    end
  end

  // ---------------- directed sequence ----------------
  bit found;
  initial begin
    nub_resetn = 1'b0;
    req_i      = '0;
    lock_i     = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    repeat (3) @(posedge nub_clkn);
    #1;
    chk("reset_gnt",     32'(gnt_o), 32'h0);
    chk("reset_done",    32'(done_o), 32'h0);
    chk("reset_err",     32'(err_o), 32'h0);
    chk("reset_busy",    32'(sched_busy_o), 32'h0);
    chk("reset_masterd", 32'(mst_masterd_o), 32'h0);
    chk("reset_lock",    32'(mst_lock_o), 32'h0);
    @(negedge nub_clkn);
    nub_resetn = 1'b1;

    // single requester 0 (rr starts at 3)
    rem[0] = 1;
    push_exp(1'b0, 4'b0001, 1'b0);
    run_until_idle(100, "single");

    // all four requesting, two each; rr now 0 so order starts at 1
    for (int i = 0; i < NREQ; i++) rem[i] = 2;
    for (int r = 0; r < 2; r++) begin
      push_exp(1'b0, 4'b0010, 1'b0);
      push_exp(1'b0, 4'b0100, 1'b0);
      push_exp(1'b0, 4'b1000, 1'b0);
      push_exp(1'b0, 4'b0001, 1'b0);
    end
    run_until_idle(400, "round_robin");

    // locked requester 0 chains 4, is forced to rotate, then gets a fresh chain
    lock_i = 4'b0001;
    rem[0] = 6; rem[1] = 2;
    push_exp(1'b0, 4'b0010, 1'b0);
    for (int k = 0; k < 4; k++) push_exp(1'b1, 4'b0001, 1'b0);
    push_exp(1'b0, 4'b0010, 1'b0);
    push_exp(1'b1, 4'b0001, 1'b0);
    push_exp(1'b1, 4'b0001, 1'b0);
    run_until_idle(400, "lock_chain");
    lock_i = '0;

    // watchdog timeouts: err pulses, next requester still served
    eng_mode = 1;
    rem[0] = 1; rem[1] = 1;
    push_exp(1'b0, 4'b0010, 1'b1);
    push_exp(1'b0, 4'b0001, 1'b1);
    run_until_idle(1000, "timeout");

    // ACK and timeout in the same cycle report done only
    eng_mode = 2;
    lock_i = 4'b1000;
    rem[3] = 1;
    push_exp(1'b1, 4'b1000, 1'b0);
    run_until_idle(100, "ack_and_timeout");
    lock_i = '0;
    eng_mode = 0;

    // reset during XFER of a locked requester 2
    lock_i = 4'b0100;
    req_i  = 4'b0100;
    found  = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(posedge nub_clkn); #1;
      if (gnt_o == 4'b0100 && !mst_masterd_o && !mst_ownern_i) found = 1;
    end
    chk("reach_xfer", 32'(found), 32'h1);
    @(posedge nub_clkn); #1;
    chk("xfer_lock", 32'(mst_lock_o), 32'h1);
    #2;
    nub_resetn = 1'b0;
    #1;
    chk("async_gnt",     32'(gnt_o), 32'h0);
    chk("async_masterd", 32'(mst_masterd_o), 32'h0);
    chk("async_lock",    32'(mst_lock_o), 32'h0);
    chk("async_busy",    32'(sched_busy_o), 32'h0);
    req_i  = '0;
    lock_i = '0;
    repeat (2) @(negedge nub_clkn);
    nub_resetn = 1'b1;
    chk("no_pending_after_reset", 32'(exp_q.size()), 32'h0);

    // after reset requester 0 wins first again
    for (int i = 0; i < NREQ; i++) rem[i] = 1;
    push_exp(1'b0, 4'b0001, 1'b0);
    push_exp(1'b0, 4'b0010, 1'b0);
    push_exp(1'b0, 4'b0100, 1'b0);
    push_exp(1'b0, 4'b1000, 1'b0);
    run_until_idle(300, "after_reset");

    repeat (3) @(posedge nub_clkn);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
